// File: rtl/dual_issue_scheduler.sv
// Dual-issue controller: checks the two fetch-buffer head instructions against a
// per-register in-flight scoreboard and each other, and drives issue/freeze controls.
module dual_issue_scheduler #(
    parameter int unsigned ALU_LAT  = 1,
    parameter int unsigned LOAD_LAT = 3
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        nothing_filled,
    input  logic [31:0] instruction0,
    input  logic [31:0] instruction1,
    input  logic        flush,
    output logic        freeze1,
    output logic        freeze2,
    output logic        dependency_on_ins2,
    output logic        issue0_valid,
    output logic        issue1_valid,
    output logic [31:0] issue0_instr,
    output logic [31:0] issue1_instr,
    output logic [15:0] stall_cycles,
    output logic [31:0] busy_dbg
);

    // Handshake: the buffer samples freeze1/dependency_on_ins2 at the clock edge;
    // freeze1=1 holds it, dep=1 slides by one, otherwise it slides by two.

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_L  = 4'(ALU_LAT);
    localparam logic [3:0] LOAD_L = 4'(LOAD_LAT);

    typedef struct packed {
        logic       reads1;
        logic       reads2;
        logic       writes;
        logic       is_mem;
        logic       is_ctrl;
        logic       is_load;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t d;
        logic wr;
        d         = '0;
        d.rs1     = ins[19:15];
        d.rs2     = ins[24:20];
        d.rd      = ins[11:7];
        wr        = 1'b0;
        unique case (ins[6:0])
            OPC_LOAD:   begin d.reads1 = 1'b1; wr = 1'b1; d.is_mem = 1'b1; d.is_load = 1'b1; end
            OPC_STORE:  begin d.reads1 = 1'b1; d.reads2 = 1'b1; d.is_mem = 1'b1; end
            OPC_BRANCH: begin d.reads1 = 1'b1; d.reads2 = 1'b1; d.is_ctrl = 1'b1; end
            OPC_JALR:   begin d.reads1 = 1'b1; wr = 1'b1; d.is_ctrl = 1'b1; end
            OPC_JAL:    begin wr = 1'b1; d.is_ctrl = 1'b1; end
            OPC_OPIMM:  begin d.reads1 = 1'b1; wr = 1'b1; end
            OPC_OP:     begin d.reads1 = 1'b1; d.reads2 = 1'b1; wr = 1'b1; end
            OPC_LUI:    wr = 1'b1;
            OPC_AUIPC:  wr = 1'b1;
            OPC_SYSTEM: d.is_ctrl = 1'b1;
            default:    d.is_ctrl = 1'b1;
        endcase
        // x0 is never a source of dependency nor a scoreboard target
        d.reads1 = d.reads1 && (d.rs1 != 5'd0);
        d.reads2 = d.reads2 && (d.rs2 != 5'd0);
        d.writes = wr && (d.rd != 5'd0);
        return d;
    endfunction

    logic [3:0]  cnt_q [32];
    logic [3:0]  cnt_d [32];
    logic [15:0] stall_q, stall_d;
    logic [31:0] busy;
    dec_t        d0, d1;
    logic        hazard0, hazard1, pair_conflict;

    always_comb begin
        for (int r = 0; r < 32; r++) busy[r] = (cnt_q[r] != 4'd0);
    end

    assign d0 = decode(instruction0);
    assign d1 = decode(instruction1);

    assign hazard0 = (d0.reads1 && busy[d0.rs1]) || (d0.reads2 && busy[d0.rs2]) ||
                     (d0.writes && busy[d0.rd]);
    assign hazard1 = (d1.reads1 && busy[d1.rs1]) || (d1.reads2 && busy[d1.rs2]) ||
                     (d1.writes && busy[d1.rd]);

    assign pair_conflict =
        (d0.writes && ((d1.reads1 && d1.rs1 == d0.rd) || (d1.reads2 && d1.rs2 == d0.rd) ||
                       (d1.writes && d1.rd == d0.rd))) ||
        hazard1 || (d0.is_mem && d1.is_mem) || d0.is_ctrl || d1.is_ctrl ||
        (instruction1 == 32'd0);

    always_comb begin
        freeze1            = 1'b1;
        freeze2            = 1'b1;
        dependency_on_ins2 = 1'b0;
        issue0_valid       = 1'b0;
        issue1_valid       = 1'b0;
        if (!n_rst || nothing_filled || hazard0) begin
            freeze1 = 1'b1;
        end else if (pair_conflict) begin
            freeze1            = 1'b0;
            dependency_on_ins2 = 1'b1;
            issue0_valid       = 1'b1;
        end else begin
            freeze1      = 1'b0;
            freeze2      = 1'b0;
            issue0_valid = 1'b1;
            issue1_valid = 1'b1;
        end
    end

    assign issue0_instr = issue0_valid ? instruction0 : 32'd0;
    assign issue1_instr = issue1_valid ? instruction1 : 32'd0;

    always_comb begin
        for (int r = 0; r < 32; r++) begin
            cnt_d[r] = (flush || cnt_q[r] == 4'd0) ? 4'd0 : cnt_q[r] - 4'd1;
        end
        // A fresh issue overrides the decrement of its own entry
        if (!flush) begin
            if (issue0_valid && d0.writes) cnt_d[d0.rd] = d0.is_load ? LOAD_L : ALU_L;
            if (issue1_valid && d1.writes) cnt_d[d1.rd] = d1.is_load ? LOAD_L : ALU_L;
        end
        stall_d = stall_q;
        if (freeze1 && !nothing_filled && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int r = 0; r < 32; r++) cnt_q[r] <= 4'd0;
            stall_q <= 16'd0;
        end else begin
            for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
    assign busy_dbg     = busy;

endmodule

// File: doc/dual_issue_scheduler.md
# dual_issue_scheduler

Issue controller between the instruction fetch buffer and the two execution slots. Each cycle it inspects the buffer's two head instructions (RV32I), checks them against a per-register scoreboard of in-flight writes and against each other, and drives the buffer's `freeze1`, `freeze2` and `dependency_on_ins2` controls. It also forwards issued instructions to slot 0 and slot 1 and keeps a saturating stall counter.

## Interface
- `ALU_LAT`, 1: cycles a non-load result stays busy after issue (0..15; 0 means no scoreboard entry).
- `LOAD_LAT`, 3: cycles a load result stays busy after issue (0..15).

Ports:
- `clk`  in  1  clock.
- `n_rst`  in  1  asynchronous active-low reset.
- `nothing_filled`  in  1  buffer empty; head instructions are invalid.
- `instruction0`  in  32  buffer head (older).
- `instruction1`  in  32  buffer head+1.
- `flush`  in  1  synchronous clear of all scoreboard counters (redirect).
- `freeze1`  out  1  buffer must hold; nothing issues.
- `freeze2`  out  1  slot 1 does not issue this cycle.
- `dependency_on_ins2`  out  1  only instruction0 issues; buffer slides by 1.
- `issue0_valid`, `issue1_valid`  out  1 each  slot issue strobes.
- `issue0_instr`, `issue1_instr`  out  32 each  instruction0/instruction1 when the matching valid is 1, else 0.
- `stall_cycles`  out  16  count of cycles with `freeze1`=1 and `nothing_filled`=0, saturating at 0xFFFF.

## Operation
- Decode uses opcode [6:0], rd [11:7], rs1 [19:15] and rs2 [24:20].
  - Reads rs1: LOAD, STORE, BRANCH, JALR, OP-IMM, OP.
  - Reads rs2: STORE, BRANCH, OP.
  - Writes rd: LOAD, JAL, JALR, OP-IMM, OP, LUI, AUIPC, and only when rd≠0.
  - Register x0 is never busy and never a dependency.
  - Memory op: LOAD or STORE. Control op: BRANCH, JAL, JALR, SYSTEM.
  - Unknown opcode or all-zero word: no register use; counts as a control op.
- Scoreboard: 32 counters of 4 bits. `busy[r]` = (counter≠0).
- `hazard0`: instruction0 reads a busy register, or writes a busy rd (WAW).
- `pair_conflict`, any of the following:
  - instruction1 reads instruction0's rd.
  - Both instructions write the same rd.
  - instruction1 has a scoreboard hazard (same rule as `hazard0`).
  - Both are memory ops (single LSU).
  - instruction0 is a control op.
  - instruction1 is a control op.
  - instruction1 = 0.
- Decision, in priority order, combinational:
  1. `nothing_filled`=1 → `freeze1`=1, `freeze2`=1, dep=0, no issue.
  2. `hazard0` → `freeze1`=1, `freeze2`=1, dep=0, no issue.
  3. `pair_conflict` → `freeze1`=0, `freeze2`=1, dep=1, issue0 only.
  4. Otherwise → all controls 0, both slots issue.
- Scoreboard update at each clock edge, in priority order:
  1. `flush` → all counters 0. Any issue in the same cycle is still driven to the outputs but is not recorded.
  2. Otherwise, every nonzero counter decrements by 1.
  3. Then each issued writer loads `counter[rd]` with LOAD_LAT (load) or ALU_LAT (other). A load wins over the decrement of the same entry.
  - Slots never write the same rd in one cycle, because that case is a pair conflict.
- `stall_cycles` increments on every edge where `freeze1`=1 and `nothing_filled`=0. It holds at 0xFFFF. It is not cleared by `flush`.

## Timing
- Reset (asynchronous, `n_rst`=0): all counters 0 and `stall_cycles`=0.
  - Outputs while in reset: `freeze1`=1, `freeze2`=1, dep=0, both valids 0, both instr buses 0.
  - A reset asserted mid-operation drops all in-flight busy state immediately.
- All issue and freeze outputs are combinational from the inputs and the registered scoreboard, with zero-cycle latency.
- A producer issued in cycle t with latency L:
  - Its rd is busy in cycles t+1..t+L.
  - A consumer may issue in cycle t+L+1.
  - With L=0 the consumer may issue in cycle t+1, but never paired in the same cycle as the producer.
- Buffer contract: when `freeze1`=1 the buffer holds; when dep=1 it slides by 1; otherwise it slides by 2. Outputs must be stable before the edge.

## Test plan
- Reset release with empty buffer (`nothing_filled`=1): outputs are `freeze1`=1, `freeze2`=1, valids 0; `stall_cycles` stays 0.
- Independent pair 0x00500093 (addi x1,x0,5) and 0x00100193 (addi x3,x0,1): both valids 1, all controls 0. Next cycle `busy[1]` and `busy[3]` are 1 for exactly ALU_LAT=1 cycle.
- Intra-pair RAW, 0x00500093 then 0x00108133 (add x2,x1,x1): dep=1, `freeze2`=1, issue0 only. Next cycle with add at head: `freeze1`=1 for 1 cycle, then issue0 in cycle t+2.
- Load-use, 0x00002283 (lw x5) issued at t, then 0x00502023 (sw x5): `freeze1`=1 in t+1..t+3, issue at t+4, `stall_cycles`=3. Separately, lw followed by sw with no data dependency still issues singly (dep=1, LSU conflict).
- Control op, 0x00000063 (beq) at head with an addi behind it: dep=1, only the beq issues. An all-zero instruction1 behind an add also gives dep=1.
- `flush` asserted the cycle after lw x5 issues: next cycle `busy[5]`=0 and sw x5 issues immediately. Reset asserted mid-stall clears the stall the same cycle.
